// File: rtl/spi_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_bank_pkg
// Description : Shared definitions for the extension-board control block.
//               Holds the bit positions of the fields carried in the control
//               access address, and the auto-transfer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_bank_pkg;

  // Field positions inside the 16-bit control access address
  localparam int CTRL_MOSI   = 15;  // manual MOSI level
  localparam int CTRL_AUTO   = 14;  // 1 = hardware byte engine owns SCK/MOSI
  localparam int CTRL_BANKHI = 8;   // upper bank bits start here (BANK_W > 2)
  localparam int CTRL_BANKLO = 6;   // bank bits [1:0]
  localparam int CTRL_ZP     = 5;   // zero-page swap, active low
  localparam int CTRL_POL    = 4;   // clock polarity; idle SCK = ~POL
  localparam int CTRL_SS     = 2;   // two slave selects, active low
  localparam int CTRL_SCLK   = 0;   // manual SCLK bit / status read enable

  // Auto-transfer FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,   // waiting to emit the leading SCK edge of a bit
    ST_TRAIL = 2'd2    // waiting to emit the trailing SCK edge of a bit
  } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_bank_ctrl_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_shifter
// Description : Hardware SPI word engine. A start strobe loads the TX word
//               and the divider; each bit takes two half-periods of DIV+1
//               clocks. MOSI changes on trailing edges, MISO is sampled on
//               leading edges. An abort returns to idle without DONE.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_start           - begin a transfer (caller guarantees idle)
//               i_abort           - cancel an in-flight transfer
//               i_idle_sck        - SCK level to hold while idle / on abort
//               i_data, i_div     - TX word and half-period divider
//               i_miso            - serial input
//               o_sck, o_mosi     - serial clock / data out (registered)
//               o_busy, o_done    - transfer in progress / completion pulse
//               o_rxdata          - last completed received word
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shifter
  import spi_bank_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_idle_sck,
  input  logic [NBITS-1:0] i_data,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_miso,
  output logic             o_sck,
  output logic             o_mosi,
  output logic             o_busy,
  output logic             o_done,
  output logic [NBITS-1:0] o_rxdata
);

  localparam int                 c_CNT_W    = $clog2(NBITS);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(NBITS - 1);

  xfer_state_t        r_state;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [c_CNT_W-1:0] r_bitcnt;
  logic [NBITS-1:0]   r_shift;
  logic [NBITS-1:0]   r_rxdata;
  logic               r_sck;
  logic               r_mosi;
  logic               r_busy;
  logic               r_done;
  logic               w_div_hit;

  // Half-period elapses when the counter reaches the divider latched at start
  assign w_div_hit = (r_div_cnt == r_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_div_cnt <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_rxdata  <= '0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_state   <= ST_IDLE;
        r_busy    <= 1'b0;
        r_sck     <= i_idle_sck;
        r_div_cnt <= '0;
        r_bitcnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Track polarity changes so SCK is correct when a transfer starts
            r_sck <= i_idle_sck;
            if (i_start) begin
              r_shift   <= i_data;
              r_mosi    <= i_data[NBITS-1];
              r_div     <= i_div;
              r_div_cnt <= '0;
              r_bitcnt  <= '0;
              r_busy    <= 1'b1;
              r_state   <= ST_LEAD;
            end
          end
          ST_LEAD: begin
            if (w_div_hit) begin
              r_div_cnt <= '0;
              r_sck     <= ~r_sck;
              // Shift left: the next TX bit moves to the MSB, MISO enters LSB
              r_shift   <= {r_shift[NBITS-2:0], i_miso};
              r_state   <= ST_TRAIL;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
          ST_TRAIL: begin
            if (w_div_hit) begin
              r_div_cnt <= '0;
              r_sck     <= ~r_sck;
              if (r_bitcnt == c_LAST_BIT) begin
                r_rxdata <= r_shift;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= ST_IDLE;
              end else begin
                r_mosi   <= r_shift[NBITS-1];
                r_bitcnt <= r_bitcnt + c_CNT_W'(1);
                r_state  <= ST_LEAD;
              end
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sck    = r_sck;
  assign o_mosi   = r_mosi;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_rxdata = r_rxdata;

endmodule
`default_nettype wire

// File: rtl/spi_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_bank_ctrl
// Description : Control-register block for the extension board. Decoded
//               control writes (data carried in the address) latch the RAM
//               bank, zero-page swap, slave selects, SPI polarity and mode.
//               In manual mode SCK/MOSI are bit-banged from control writes;
//               in auto mode a DATA_WE starts an NBITS hardware transfer.
// Ports       : CLK, nRESET       - clock, async active-low reset
//               CTRL_WE, CTRL_A   - control write strobe and its address
//               DATA_WE, DATA_IN  - TX word write (auto mode)
//               DIV               - SCK half-period = DIV+1 clocks
//               MISO              - serial in
//               SCK, MOSI, nSS    - SPI pins
//               BANK, nZPBANK     - RAM banking controls
//               SCLK_EN           - manual SCLK bit / status read enable
//               RXDATA, BUSY,
//               DONE, OVR         - auto engine status
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bank_ctrl
  import spi_bank_pkg::*;
#(
  parameter int BANK_W = 2,
  parameter int NBITS  = 8,
  parameter int DIV_W  = 4
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              CTRL_WE,
  input  logic [15:0]       CTRL_A,
  input  logic              DATA_WE,
  input  logic [NBITS-1:0]  DATA_IN,
  input  logic [DIV_W-1:0]  DIV,
  input  logic              MISO,
  output logic              SCK,
  output logic              MOSI,
  output logic [1:0]        nSS,
  output logic [BANK_W-1:0] BANK,
  output logic              nZPBANK,
  output logic              SCLK_EN,
  output logic [NBITS-1:0]  RXDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVR
);

  logic [BANK_W-1:0] r_bank;
  logic              r_nzp;
  logic [1:0]        r_nss;
  logic              r_pol;
  logic              r_auto;
  logic              r_sclk_en;
  logic              r_man_mosi;
  logic              r_man_sck;
  logic              r_ovr;

  logic [BANK_W-1:0] w_bank_next;
  logic              w_auto_eff;
  logic              w_pol_eff;
  logic              w_busy;
  logic              w_start;
  logic              w_abort;
  logic              w_auto_sck;
  logic              w_auto_mosi;
  logic              w_unused;

  // Bank bits are split across the address: [1:0] low, the rest higher up
  assign w_bank_next[1:0] = CTRL_A[CTRL_BANKLO +: 2];
  generate
    if (BANK_W > 2) begin : g_bank_hi
      assign w_bank_next[BANK_W-1:2] = CTRL_A[CTRL_BANKHI +: (BANK_W - 2)];
    end
  endgenerate

  // A control write in the same cycle as DATA_WE takes effect first, so the
  // start decision and idle polarity look through to the incoming values.
  assign w_auto_eff = CTRL_WE ? CTRL_A[CTRL_AUTO] : r_auto;
  assign w_pol_eff  = CTRL_WE ? CTRL_A[CTRL_POL]  : r_pol;
  assign w_start    = DATA_WE & w_auto_eff & ~w_busy;
  assign w_abort    = CTRL_WE & ~CTRL_A[CTRL_AUTO] & w_busy;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_bank     <= '0;
      r_nzp      <= 1'b1;
      r_nss      <= 2'b11;
      r_pol      <= 1'b1;
      r_auto     <= 1'b0;
      r_sclk_en  <= 1'b0;
      r_man_mosi <= 1'b0;
      r_man_sck  <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (CTRL_WE) begin
        r_bank <= w_bank_next;
        r_nzp  <= CTRL_A[CTRL_ZP];
        r_nss  <= CTRL_A[CTRL_SS +: 2];
        r_pol  <= CTRL_A[CTRL_POL];
        r_auto <= CTRL_A[CTRL_AUTO];
        r_ovr  <= 1'b0;
        if (!w_busy) begin
          r_sclk_en  <= CTRL_A[CTRL_SCLK];
          r_man_mosi <= CTRL_A[CTRL_MOSI];
          r_man_sck  <= ~(CTRL_A[CTRL_SCLK] ^ CTRL_A[CTRL_POL]);
        end else if (w_abort) begin
          // Aborting hands SCK back to the manual path; park it at idle
          r_man_sck <= ~CTRL_A[CTRL_POL];
        end
      end
      // A word written while busy is dropped; flag it (wins over the clear)
      if (DATA_WE && w_busy) begin
        r_ovr <= 1'b1;
      end
    end
  end

  spi_shifter #(
    .NBITS (NBITS),
    .DIV_W (DIV_W)
  ) u_shifter (
    .clk        (CLK),
    .rst_n      (nRESET),
    .i_start    (w_start),
    .i_abort    (w_abort),
    .i_idle_sck (~w_pol_eff),
    .i_data     (DATA_IN),
    .i_div      (DIV),
    .i_miso     (MISO),
    .o_sck      (w_auto_sck),
    .o_mosi     (w_auto_mosi),
    .o_busy     (w_busy),
    .o_done     (DONE),
    .o_rxdata   (RXDATA)
  );

  // Both sources are registers; the select is the registered AUTO bit
  assign SCK     = r_auto ? w_auto_sck  : r_man_sck;
  assign MOSI    = r_auto ? w_auto_mosi : r_man_mosi;
  assign nSS     = r_nss;
  assign BANK    = r_bank;
  assign nZPBANK = r_nzp;
  assign SCLK_EN = r_sclk_en;
  assign BUSY    = w_busy;
  assign OVR     = r_ovr;

  // Several address bits carry no field
  assign w_unused = ^CTRL_A;

endmodule
`default_nettype wire

// File: tb/tb_spi_bank_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_bank_ctrl
// Description : Self-checking bench for spi_bank_ctrl (BANK_W=4, NBITS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bank_ctrl;

  localparam int BANK_W = 4;
  localparam int NBITS  = 8;
  localparam int DIV_W  = 4;

  logic              CLK     = 1'b0;
  logic              nRESET  = 1'b0;
  logic              CTRL_WE = 1'b0;
  logic [15:0]       CTRL_A  = '0;
  logic              DATA_WE = 1'b0;
  logic [NBITS-1:0]  DATA_IN = '0;
  logic [DIV_W-1:0]  DIV     = '0;
  logic              MISO;
  logic              SCK;
  logic              MOSI;
  logic [1:0]        nSS;
  logic [BANK_W-1:0] BANK;
  logic              nZPBANK;
  logic              SCLK_EN;
  logic [NBITS-1:0]  RXDATA;
  logic              BUSY;
  logic              DONE;
  logic              OVR;

  logic r_inv = 1'b0;   // 1: MISO = ~MOSI, else straight loopback
  assign MISO = r_inv ? ~MOSI : MOSI;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the board's registers should hold
  logic [BANK_W-1:0] m_bank;
  logic              m_nzp;
  logic [1:0]        m_nss;
  logic              m_pol;
  logic              m_auto;
  logic              m_sclk_en;
  logic              m_mosi;
  logic              m_sck;
  logic [NBITS-1:0]  m_rx;

  spi_bank_ctrl #(.BANK_W(BANK_W), .NBITS(NBITS), .DIV_W(DIV_W)) dut (
    .CLK(CLK), .nRESET(nRESET), .CTRL_WE(CTRL_WE), .CTRL_A(CTRL_A),
    .DATA_WE(DATA_WE), .DATA_IN(DATA_IN), .DIV(DIV), .MISO(MISO),
    .SCK(SCK), .MOSI(MOSI), .nSS(nSS), .BANK(BANK), .nZPBANK(nZPBANK),
    .SCLK_EN(SCLK_EN), .RXDATA(RXDATA), .BUSY(BUSY), .DONE(DONE), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_bank = '0; m_nzp = 1'b1; m_nss = 2'b11; m_pol = 1'b1; m_auto = 1'b0;
    m_sclk_en = 1'b0; m_mosi = 1'b0; m_sck = 1'b0; m_rx = '0;
  endtask

  // Meaning of a control write, from the address fields
  task automatic model_ctrl(input logic [15:0] a, input logic busy);
    m_bank = {a[9:8], a[7:6]};
    m_nzp  = a[5];
    m_nss  = a[3:2];
    m_pol  = a[4];
    m_auto = a[14];
    if (!busy) begin
      m_sclk_en = a[0];
      m_mosi    = a[15];
      m_sck     = ~(a[0] ^ a[4]);
    end else if (!a[14]) begin
      m_sck = ~a[4];
    end
  endtask

  task automatic ctrl_write(input logic [15:0] a, input logic busy);
    CTRL_A = a; CTRL_WE = 1'b1;
    tick();
    CTRL_WE = 1'b0;
    model_ctrl(a, busy);
  endtask

  // Runs one auto transfer and checks its bit stream, timing and result.
  // ovr_at > 0 injects an extra DATA_WE after that many cycles.
  task automatic run_xfer(input string name, input logic [NBITS-1:0] data,
                          input int div, input logic inv, input int ovr_at,
                          input logic with_ctrl, input logic [15:0] ctrl_a);
    int cycles, edges, exp_len;
    logic prev, pol, got_done;
    logic [NBITS-1:0] seq, exp_rx;
    exp_len = 2 * NBITS * (div + 1);
    r_inv = inv; DATA_IN = data; DIV = DIV_W'(div); DATA_WE = 1'b1;
    if (with_ctrl) begin CTRL_A = ctrl_a; CTRL_WE = 1'b1; end
    tick();
    DATA_WE = 1'b0; CTRL_WE = 1'b0;
    if (with_ctrl) model_ctrl(ctrl_a, 1'b0);
    pol = m_pol;
    checks++;
    if ({BUSY, SCK, MOSI, DONE} !== {1'b1, ~pol, data[NBITS-1], 1'b0}) begin
      failures++;
      $display("FAIL %s_start: busy/sck/mosi/done got %b expected %b", name,
               {BUSY, SCK, MOSI, DONE}, {1'b1, ~pol, data[NBITS-1], 1'b0});
    end
    cycles = 0; edges = 0; prev = SCK; seq = '0; got_done = 1'b0;
    while (!got_done && cycles < exp_len + 8) begin
      if (ovr_at > 0 && cycles == ovr_at) begin DATA_IN = ~data; DATA_WE = 1'b1; end
      tick();
      DATA_WE = 1'b0;
      cycles++;
      if (SCK !== prev) begin
        edges++;
        if (SCK === pol) seq = {seq[NBITS-2:0], MOSI};
        prev = SCK;
      end
      if (DONE === 1'b1) got_done = 1'b1;
    end
    exp_rx = inv ? ~data : data;
    checks++;
    if (!got_done || cycles != exp_len) begin
      failures++;
      $display("FAIL %s_len: done=%0b after %0d cycles, expected %0d", name, got_done, cycles, exp_len);
    end
    checks++;
    if (edges != 2 * NBITS) begin
      failures++;
      $display("FAIL %s_edges: got %0d SCK edges expected %0d", name, edges, 2 * NBITS);
    end
    checks++;
    if (seq !== data) begin
      failures++;
      $display("FAIL %s_mosi: got stream %h expected %h", name, seq, data);
    end
    checks++;
    if ({RXDATA, BUSY, SCK} !== {exp_rx, 1'b0, ~pol}) begin
      failures++;
      $display("FAIL %s_end: rx/busy/sck got %h expected %h", name, {RXDATA, BUSY, SCK}, {exp_rx, 1'b0, ~pol});
    end
    m_rx = exp_rx;
    if (ovr_at > 0) begin
      checks++;
      if (OVR !== 1'b1) begin
        failures++;
        $display("FAIL %s_ovr: got %b expected 1", name, OVR);
      end
    end
    tick();
    checks++;
    if (DONE !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: got %b expected 0", name, DONE);
    end
  endtask

  task automatic test_reset();
    model_reset();
    tick(); tick();
    checks++;
    if ({BANK, nZPBANK, nSS, SCLK_EN, SCK, MOSI, RXDATA, BUSY, DONE, OVR} !==
        {4'h0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: got %h expected %h",
               {BANK, nZPBANK, nSS, SCLK_EN, SCK, MOSI, RXDATA, BUSY, DONE, OVR},
               {4'h0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    end
    nRESET = 1'b1;
    tick(); tick();
    checks++;
    if ({BUSY, DONE, OVR, nSS} !== {1'b0, 1'b0, 1'b0, 2'b11}) begin
      failures++;
      $display("FAIL reset_release: got %b expected 00011", {BUSY, DONE, OVR, nSS});
    end
  endtask

  task automatic test_ctrl_write();
    logic [15:0] a;
    ctrl_write(16'h80C1, 1'b0);
    checks++;
    if ({BANK, nZPBANK, nSS, MOSI, SCK, SCLK_EN} !== {4'd3, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ctrl_80C1: got %b expected %b", {BANK, nZPBANK, nSS, MOSI, SCK, SCLK_EN},
               {4'd3, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1});
    end
    ctrl_write(16'h0340, 1'b0);
    checks++;
    if (BANK !== 4'b1101) begin
      failures++;
      $display("FAIL ctrl_bank_hi: got %b expected 1101", BANK);
    end
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      a[14] = 1'b0;
      ctrl_write(a, 1'b0);
      checks++;
      if ({BANK, nZPBANK, nSS, MOSI, SCK, SCLK_EN, OVR} !==
          {m_bank, m_nzp, m_nss, m_mosi, m_sck, m_sclk_en, 1'b0}) begin
        failures++;
        $display("FAIL ctrl_rand A=%h: got %b expected %b", a,
                 {BANK, nZPBANK, nSS, MOSI, SCK, SCLK_EN, OVR},
                 {m_bank, m_nzp, m_nss, m_mosi, m_sck, m_sclk_en, 1'b0});
      end
    end
  endtask

  task automatic test_auto_basic();
    ctrl_write(16'h4010, 1'b0);   // AUTO=1, POL=1
    run_xfer("basic", 8'hA5, 1, 1'b0, 0, 1'b0, 16'h0);
  endtask

  task automatic test_overrun();
    run_xfer("ovr", 8'h3C, 1, 1'b1, 5, 1'b0, 16'h0);
    ctrl_write(16'h4010, 1'b0);
    checks++;
    if (OVR !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear: got %b expected 0", OVR);
    end
  endtask

  task automatic test_abort();
    logic [NBITS-1:0] old_rx;
    logic newpol;
    int done_seen;
    old_rx = m_rx;
    newpol = 1'($urandom);
    r_inv = 1'b0; DATA_IN = 8'h96; DIV = 4'd1; DATA_WE = 1'b1;
    tick();
    DATA_WE = 1'b0;
    for (int i = 0; i < 14; i++) tick();   // into bit 3
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_busy: got %b expected 1", BUSY);
    end
    ctrl_write({1'b0, 1'b0, 9'h0, newpol, 4'h0}, 1'b1);
    checks++;
    if ({BUSY, SCK, DONE, RXDATA} !== {1'b0, ~newpol, 1'b0, old_rx}) begin
      failures++;
      $display("FAIL abort: busy/sck/done/rx got %h expected %h",
               {BUSY, SCK, DONE, RXDATA}, {1'b0, ~newpol, 1'b0, old_rx});
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DONE === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0 || RXDATA !== old_rx) begin
      failures++;
      $display("FAIL abort_quiet: done pulses %0d rx %h expected 0 and %h", done_seen, RXDATA, old_rx);
    end
  endtask

  task automatic test_data_no_auto();
    DATA_IN = 8'h5A; DATA_WE = 1'b1;
    tick();
    DATA_WE = 1'b0;
    tick(); tick();
    checks++;
    if ({BUSY, OVR, DONE} !== 3'b000) begin
      failures++;
      $display("FAIL noauto: busy/ovr/done got %b expected 000", {BUSY, OVR, DONE});
    end
  endtask

  task automatic test_simultaneous();
    logic pol;
    pol = 1'($urandom);
    run_xfer("simul", 8'($urandom), 0, 1'b1, 0, 1'b1, {1'b0, 1'b1, 9'h0, pol, 4'h0});
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      a[14] = 1'b1;
      ctrl_write(a, 1'b0);
      run_xfer("rand", 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 0, 1'b0, 16'h0);
    end
  endtask

  task automatic test_async_reset();
    ctrl_write(16'h4020, 1'b0);   // AUTO=1, POL=0
    DATA_IN = 8'hC3; DIV = 4'd2; DATA_WE = 1'b1;
    tick();
    DATA_WE = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    @(posedge CLK);
    #3 nRESET = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({BANK, nZPBANK, nSS, SCLK_EN, SCK, MOSI, RXDATA, BUSY, DONE, OVR} !==
        {4'h0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h",
               {BANK, nZPBANK, nSS, SCLK_EN, SCK, MOSI, RXDATA, BUSY, DONE, OVR},
               {4'h0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    end
    #2 nRESET = 1'b1;
    tick(); tick();
    checks++;
    if ({BUSY, DONE, SCK} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset_idle: got %b expected 000", {BUSY, DONE, SCK});
    end
    ctrl_write(16'h4010, 1'b0);
    run_xfer("post_reset", 8'h71, 0, 1'b0, 0, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_ctrl_write();
    test_auto_basic();
    test_overrun();
    test_abort();
    test_data_no_auto();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
